mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-ported, tagged main-memory interface between the icache
//  miss path (feeding fetch) and the dcache (loads/stores). Issues at most one
//  command per cycle and records which requester owns each accepted transaction
//  tag. Routes each returning data tag to its owner and drops icache fills
//  squashed by a taken branch. Sits between both caches and the memory model.
// PARAMETERS
//  NUM_TAGS      15  memory tags 1..NUM_TAGS; tag 0 means "rejected"/"no data"
//  STARVE_LIMIT  4   consecutive cycles an icache request may lose before it wins
// PORTS
//  clock                    in   1   system clock, all state on posedge
//  reset                    in   1   synchronous, active-low; low at posedge clears state
//  ic_req_valid             in   1   icache miss request pending (held until ready)
//  ic_req_addr              in   32  block address, [2:0] ignored
//  ic_req_ready             out  1   icache request accepted by memory this cycle
//  dc_req_valid             in   1   dcache request pending (held until ready)
//  dc_req_cmd               in   2   BUS_LOAD or BUS_STORE
//  dc_req_addr              in   32  block address
//  dc_req_data              in   64  store data
//  dc_req_ready             out  1   dcache request accepted this cycle
//  ic_flush                 in   1   taken branch: squash outstanding icache fills
//  proc2mem_command         out  2   BUS_NONE/BUS_LOAD/BUS_STORE
//  proc2mem_addr            out  32  address of granted request
//  proc2mem_data            out  64  store data (0 unless store granted)
//  mem2proc_transaction_tag in   4   nonzero = command accepted with this tag
//  mem2proc_data            in   64  returning data
//  mem2proc_data_tag        in   4   nonzero = data for this tag is valid now
//  ic_resp_valid/_data      out  1/64  fill data for icache
//  dc_resp_valid/_data      out  1/64  load data for dcache
//  dc_resp_tag              out  4   tag of the dcache response
//  outstanding_cnt          out  5   number of live entries in the tag table
//  err_unexpected           out  1   sticky: data_tag arrived with no live entry
// BEHAVIOUR
//  - Reset: tag table empty, FSM=DC_PRI, starve_cnt=0, err_unexpected=0.
//    All outputs read 0 / BUS_NONE while reset is low.
//  - Tag table: per tag {valid, owner(IC/DC), squashed}. Stores get no entry;
//    no data is returned for them.
//  - FSM DC_PRI: dcache wins if both requesters are valid.
//    FSM IC_PRI: icache wins.
//  - starve_cnt increments (saturating) each cycle ic_req_valid is high and not
//    accepted, and clears on icache accept.
//    DC_PRI->IC_PRI when starve_cnt==STARVE_LIMIT-1 and the icache loses again.
//    IC_PRI->DC_PRI on icache accept.
//  - Issue: the winner drives proc2mem_* combinationally in the same cycle.
//    Accepted iff mem2proc_transaction_tag!=0; then the winner's *_ready=1 that
//    cycle and the entry is written at posedge.
//    Tag 0: ready=0 and the requester retries; the FSM does not change except
//    via starve_cnt.
//  - Full: outstanding_cnt==NUM_TAGS means command=BUS_NONE and both readies 0.
//    Stores are also blocked; this keeps the policy simple.
//  - Response (0-cycle): data_tag!=0 with a valid entry clears it at posedge.
//    Owner DC: dc_resp_valid=1, dc_resp_data=mem2proc_data, dc_resp_tag=data_tag.
//    Owner IC, not squashed: ic_resp_valid=1. Squashed: dropped silently.
//    No valid entry: no resp; err_unexpected set next cycle.
//  - ic_flush: all valid IC entries get squashed=1 at posedge.
//    An icache request accepted in the same cycle is NOT squashed.
//    The icache must deassert any stale request itself.
//  - Same-cycle response and new accept on the same tag: clear, then set.
//    The new entry survives.
//  - outstanding_cnt = popcount(valid), range 0..NUM_TAGS.
//  - Reset mid-operation: the table is discarded. Later data tags for those
//    transactions set err_unexpected.
// TESTING
//  1 ic+dc valid, mem returns tag 3 -> dc_req_ready=1, proc2mem_addr=dc addr;
//    data_tag=3 later -> dc_resp_valid with dc_resp_tag=3.
//  2 dc valid every cycle, ic held, all accepted -> ic_req_ready=1 on the 5th
//    cycle (STARVE_LIMIT=4), then DC_PRI resumes.
//  3 Accept 15 loads without responses -> outstanding_cnt=15, command=BUS_NONE;
//    one response -> next-cycle issue resumes.
//  4 ic load tag 5 outstanding, ic_flush pulse, data_tag=5 -> no ic_resp_valid,
//    outstanding_cnt decrements.
//  5 transaction_tag=0 for 3 cycles -> ready stays 0, command retried with
//    identical addr; tag 2 on 4th cycle -> accepted.
//  6 data_tag=7 with empty table -> no resp, err_unexpected=1 next cycle and
//    held until reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the tagged main-memory port: icache misses and dcache
// loads/stores share one command slot, and returning data is routed to its owner by tag.
module mem_arbiter #(
  parameter int NUM_TAGS     = 15,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req_valid,
  input  logic [31:0]       ic_req_addr,
  output logic              ic_req_ready,
  input  logic              dc_req_valid,
  input  logic [1:0]        dc_req_cmd,
  input  logic [31:0]       dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_data,
  output logic              dc_req_ready,
  input  logic              ic_flush,
  output logic [1:0]        proc2mem_command,
  output logic [31:0]       proc2mem_addr,
  output logic [DATA_W-1:0] proc2mem_data,
  input  logic [3:0]        mem2proc_transaction_tag,
  input  logic [DATA_W-1:0] mem2proc_data,
  input  logic [3:0]        mem2proc_data_tag,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic [3:0]        dc_resp_tag,
  output logic [4:0]        outstanding_cnt,
  output logic              err_unexpected
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int         SW        = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {DC_PRI, IC_PRI} pri_e;

  pri_e               pri;
  logic [SW-1:0]      starve_cnt;
  logic               err_q;
  logic [NUM_TAGS:1]  tag_valid, tag_dc, tag_sq;
  logic [NUM_TAGS:1]  valid_n, dc_n, sq_n;
  logic [4:0]         cnt;
  logic               full, ic_win, issue, accept, alloc;
  logic               hit, hit_dc, hit_sq;
  logic               unused_addr_lsbs;

  assign unused_addr_lsbs = ^ic_req_addr[2:0];

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_LIMIT)) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cnt = '0;
    for (int t = 1; t <= NUM_TAGS; t++) cnt = cnt + 5'(tag_valid[t]);
  end

  always_comb begin
    full   = (cnt == 5'(NUM_TAGS));
    ic_win = ic_req_valid & (~dc_req_valid | (pri == IC_PRI));
    issue  = reset & ~full & (ic_req_valid | dc_req_valid);
    accept = issue & (mem2proc_transaction_tag != 4'd0);
    // Stores get no table entry because memory never answers them.
    alloc  = accept & (ic_win | (dc_req_cmd == BUS_LOAD));
  end

  always_comb begin
    hit    = 1'b0;
    hit_dc = 1'b0;
    hit_sq = 1'b0;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      if (mem2proc_data_tag == 4'(t) && tag_valid[t]) begin
        hit    = 1'b1;
        hit_dc = tag_dc[t];
        hit_sq = tag_sq[t];
      end
    end
  end

  // Retire first, then allocate, so a tag reused in the same cycle keeps the new entry.
  always_comb begin
    valid_n = tag_valid;
    dc_n    = tag_dc;
    sq_n    = tag_sq;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      if (mem2proc_data_tag == 4'(t)) valid_n[t] = 1'b0;
      if (ic_flush && tag_valid[t] && !tag_dc[t]) sq_n[t] = 1'b1;
      if (alloc && mem2proc_transaction_tag == 4'(t)) begin
        valid_n[t] = 1'b1;
        dc_n[t]    = ~ic_win;
        sq_n[t]    = 1'b0;
      end
    end
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (issue) begin
      proc2mem_command = ic_win ? BUS_LOAD : dc_req_cmd;
      proc2mem_addr    = ic_win ? {ic_req_addr[31:3], 3'b000} : dc_req_addr;
      if (!ic_win && dc_req_cmd == BUS_STORE) proc2mem_data = dc_req_data;
    end
    ic_req_ready    = accept & ic_win;
    dc_req_ready    = accept & ~ic_win;
    ic_resp_valid   = reset & hit & ~hit_dc & ~hit_sq;
    ic_resp_data    = ic_resp_valid ? mem2proc_data : '0;
    dc_resp_valid   = reset & hit & hit_dc;
    dc_resp_data    = dc_resp_valid ? mem2proc_data : '0;
    dc_resp_tag     = dc_resp_valid ? mem2proc_data_tag : 4'd0;
    outstanding_cnt = reset ? cnt : 5'd0;
    err_unexpected  = reset & err_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tag_valid  <= '0;
      tag_dc     <= '0;
      tag_sq     <= '0;
      pri        <= DC_PRI;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      tag_valid <= valid_n;
      tag_dc    <= dc_n;
      tag_sq    <= sq_n;
      if (mem2proc_data_tag != 4'd0 && !hit) err_q <= 1'b1;
      if (ic_req_ready) begin
        starve_cnt <= '0;
        pri        <= DC_PRI;
      end else if (ic_req_valid) begin
        if (pri == DC_PRI && starve_cnt == SW'(STARVE_LIMIT - 1)) pri <= IC_PRI;
        starve_cnt <= sat_inc(starve_cnt);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a tag-table reference model.
module tb_mem_arbiter;

  localparam logic [1:0]  B_NONE  = 2'd0;
  localparam logic [1:0]  B_LOAD  = 2'd1;
  localparam logic [1:0]  B_STORE = 2'd2;
  localparam int          LIMIT   = 4;
  localparam int          NT      = 15;
  localparam logic [31:0] IC_A    = 32'h1234_567F;
  localparam logic [31:0] IC_AM   = 32'h1234_5678;
  localparam logic [31:0] DC_A    = 32'h8000_0040;
  localparam logic [31:0] DC_B    = 32'h0000_2A00;
  localparam logic [63:0] DC_D    = 64'hDEAD_BEEF_0123_4567;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ic_req_valid = 1'b0, dc_req_valid = 1'b0, ic_flush = 1'b0;
  logic [31:0] ic_req_addr = '0, dc_req_addr = '0;
  logic [1:0]  dc_req_cmd = B_LOAD;
  logic [63:0] dc_req_data = '0, mem2proc_data = '0;
  logic [3:0]  mem2proc_transaction_tag = '0, mem2proc_data_tag = '0;
  logic        ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, err_unexpected;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data, ic_resp_data, dc_resp_data;
  logic [3:0]  dc_resp_tag;
  logic [4:0]  outstanding_cnt;

  always #5 clock = ~clock;

  mem_arbiter #(.NUM_TAGS(NT), .STARVE_LIMIT(LIMIT), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .dc_req_valid(dc_req_valid), .dc_req_cmd(dc_req_cmd), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_ready(dc_req_ready), .ic_flush(ic_flush),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_transaction_tag(mem2proc_transaction_tag),
    .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_tag(dc_resp_tag),
    .outstanding_cnt(outstanding_cnt), .err_unexpected(err_unexpected)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns each tag, and how long the icache has been waiting.
  bit m_val[1:NT];
  bit m_dc[1:NT];
  bit m_sq[1:NT];
  bit m_icpri;
  int m_starve;
  bit m_err;

  logic [1:0]  e_cmd;
  logic [31:0] e_addr;
  logic [63:0] e_data;
  logic        e_icr, e_dcr, e_icv, e_dcv, e_err;
  logic [3:0]  e_rtag;
  logic [4:0]  e_cnt;

  task automatic model_eval();
    int n;
    bit ic_win;
    n = 0;
    for (int t = 1; t <= NT; t++) n += m_val[t];
    e_cmd = B_NONE; e_addr = '0; e_data = '0; e_icr = 0; e_dcr = 0;
    e_icv = 0; e_dcv = 0; e_rtag = 0; e_cnt = 0; e_err = 0;
    if (reset) begin
      e_cnt = 5'(n);
      e_err = m_err;
      if (n < NT && (ic_req_valid || dc_req_valid)) begin
        ic_win = ic_req_valid && (!dc_req_valid || m_icpri);
        if (ic_win) begin
          e_cmd  = B_LOAD;
          e_addr = {ic_req_addr[31:3], 3'b000};
        end else begin
          e_cmd  = dc_req_cmd;
          e_addr = dc_req_addr;
          if (dc_req_cmd == B_STORE) e_data = dc_req_data;
        end
        if (mem2proc_transaction_tag != 0) begin
          e_icr = ic_win;
          e_dcr = !ic_win;
        end
      end
      if (mem2proc_data_tag != 0 && m_val[mem2proc_data_tag]) begin
        if (m_dc[mem2proc_data_tag]) begin
          e_dcv  = 1;
          e_rtag = mem2proc_data_tag;
        end else if (!m_sq[mem2proc_data_tag]) begin
          e_icv = 1;
        end
      end
    end
  endtask

  task automatic model_update();
    int tt, dt;
    tt = int'(mem2proc_transaction_tag);
    dt = int'(mem2proc_data_tag);
    if (!reset) begin
      for (int t = 1; t <= NT; t++) begin m_val[t] = 0; m_dc[t] = 0; m_sq[t] = 0; end
      m_icpri = 0; m_starve = 0; m_err = 0;
    end else begin
      if (dt != 0) begin
        if (m_val[dt]) m_val[dt] = 0;
        else m_err = 1;
      end
      if (ic_flush)
        for (int t = 1; t <= NT; t++) if (m_val[t] && !m_dc[t]) m_sq[t] = 1;
      if (e_icr || (e_dcr && dc_req_cmd == B_LOAD)) begin
        m_val[tt] = 1; m_dc[tt] = e_dcr; m_sq[tt] = 0;
      end
      if (e_icr) begin
        m_starve = 0; m_icpri = 0;
      end else if (ic_req_valid) begin
        if (!m_icpri && m_starve == LIMIT - 1) m_icpri = 1;
        if (m_starve < LIMIT) m_starve++;
      end
    end
  endtask

  task automatic settle();
    @(negedge clock);
    model_eval();
    chk("command", proc2mem_command, e_cmd);
    if (e_cmd != B_NONE) chk("addr", proc2mem_addr, e_addr);
    chk("wdata", proc2mem_data, e_data);
    chk("ic_ready", ic_req_ready, e_icr);
    chk("dc_ready", dc_req_ready, e_dcr);
    chk("ic_resp_valid", ic_resp_valid, e_icv);
    chk("dc_resp_valid", dc_resp_valid, e_dcv);
    if (e_icv) chk("ic_resp_data", ic_resp_data, mem2proc_data);
    if (e_dcv) begin
      chk("dc_resp_data", dc_resp_data, mem2proc_data);
      chk("dc_resp_tag", dc_resp_tag, e_rtag);
    end
    chk("outstanding", outstanding_cnt, e_cnt);
    chk("err_unexpected", err_unexpected, e_err);
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic drive(input logic icv, input logic dcv, input logic [1:0] cmd,
                       input logic [3:0] tt, input logic [3:0] dt, input logic fl);
    ic_req_valid = icv; dc_req_valid = dcv; dc_req_cmd = cmd;
    mem2proc_transaction_tag = tt; mem2proc_data_tag = dt; ic_flush = fl;
  endtask

  task automatic do_reset();
    drive(0, 0, B_LOAD, 0, 0, 0);
    reset = 1'b0;
    repeat (2) begin settle(); advance(); end
    reset = 1'b1;
  endtask

  typedef struct {
    logic icv, dcv; logic [1:0] dcmd; logic [3:0] ttag, dtag; logic flush;
    logic [1:0] cmd; logic [31:0] addr; logic [63:0] data;
    logic icr, dcr, icrv, dcrv; logic [3:0] rtag; logic [4:0] cnt; logic err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit ic_pend, dc_pend;
    int q[$];
    int dt;

    tbl[0] = '{1'b1, 1'b1, B_LOAD,  4'd3, 4'd0, 1'b0, B_LOAD,  DC_A,  64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, B_LOAD,  4'd5, 4'd3, 1'b0, B_LOAD,  IC_AM, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 5'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, B_STORE, 4'd9, 4'd0, 1'b1, B_STORE, DC_A,  DC_D,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, B_LOAD,  4'd0, 4'd5, 1'b0, B_NONE,  32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, B_LOAD,  4'd0, 4'd7, 1'b0, B_NONE,  32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, B_LOAD,  4'd0, 4'd0, 1'b0, B_NONE,  32'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, B_LOAD,  4'd0, 4'd0, 1'b0, B_LOAD,  DC_A,  64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, B_LOAD,  4'd4, 4'd0, 1'b0, B_LOAD,  DC_A,  64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, B_LOAD,  4'd4, 4'd4, 1'b0, B_LOAD,  IC_AM, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 5'd1, 1'b1};
    tbl[9] = '{1'b0, 1'b0, B_LOAD,  4'd0, 4'd4, 1'b0, B_NONE,  32'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 5'd1, 1'b1};

    #1;
    do_reset();

    // Directed vector table
    ic_req_addr = IC_A; dc_req_addr = DC_A; dc_req_data = DC_D;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].icv, tbl[i].dcv, tbl[i].dcmd, tbl[i].ttag, tbl[i].dtag, tbl[i].flush);
      mem2proc_data = 64'h0BAD_F00D_0000_0000 + 64'(i);
      settle();
      chk($sformatf("v%0d_cmd", i), proc2mem_command, tbl[i].cmd);
      if (tbl[i].cmd != B_NONE) chk($sformatf("v%0d_addr", i), proc2mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_wdata", i), proc2mem_data, tbl[i].data);
      chk($sformatf("v%0d_ic_ready", i), ic_req_ready, tbl[i].icr);
      chk($sformatf("v%0d_dc_ready", i), dc_req_ready, tbl[i].dcr);
      chk($sformatf("v%0d_ic_resp", i), ic_resp_valid, tbl[i].icrv);
      chk($sformatf("v%0d_dc_resp", i), dc_resp_valid, tbl[i].dcrv);
      if (tbl[i].dcrv) begin
        chk($sformatf("v%0d_dc_tag", i), dc_resp_tag, tbl[i].rtag);
        chk($sformatf("v%0d_dc_data", i), dc_resp_data, mem2proc_data);
      end
      if (tbl[i].icrv) chk($sformatf("v%0d_ic_data", i), ic_resp_data, mem2proc_data);
      chk($sformatf("v%0d_cnt", i), outstanding_cnt, tbl[i].cnt);
      chk($sformatf("v%0d_err", i), err_unexpected, tbl[i].err);
      advance();
    end

    // Starvation: icache wins on its 5th waiting cycle, then dcache priority returns
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive(1, 1, B_LOAD, 4'(k), 0, 0);
      settle();
      chk($sformatf("starve%0d_ic_ready", k), ic_req_ready, logic'(k == 5));
      chk($sformatf("starve%0d_dc_ready", k), dc_req_ready, logic'(k != 5));
      advance();
    end

    // Tag 0 rejects: identical retry until memory hands out tag 2
    do_reset();
    dc_req_addr = DC_B;
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, B_LOAD, (k == 4) ? 4'd2 : 4'd0, 0, 0);
      settle();
      chk($sformatf("retry%0d_ready", k), dc_req_ready, logic'(k == 4));
      chk($sformatf("retry%0d_addr", k), proc2mem_addr, DC_B);
      chk($sformatf("retry%0d_cmd", k), proc2mem_command, B_LOAD);
      advance();
    end

    // Table full: issue stops until one tag retires
    do_reset();
    dc_req_addr = DC_A;
    for (int k = 1; k <= NT; k++) begin
      drive(0, 1, B_LOAD, 4'(k), 0, 0);
      settle();
      advance();
    end
    drive(0, 1, B_LOAD, 4'd1, 0, 0);
    settle();
    chk("full_cnt", outstanding_cnt, 5'd15);
    chk("full_cmd", proc2mem_command, B_NONE);
    chk("full_ready", dc_req_ready, 1'b0);
    advance();
    drive(0, 1, B_LOAD, 4'd6, 4'd6, 0);
    settle();
    chk("full_resp_cmd", proc2mem_command, B_NONE);
    chk("full_resp_valid", dc_resp_valid, 1'b1);
    advance();
    drive(0, 1, B_LOAD, 4'd6, 0, 0);
    settle();
    chk("refill_cnt", outstanding_cnt, 5'd14);
    chk("refill_cmd", proc2mem_command, B_LOAD);
    chk("refill_ready", dc_req_ready, 1'b1);
    advance();

    // Reset with a full table: old tags become unexpected
    drive(0, 0, B_LOAD, 0, 0, 0);
    reset = 1'b0;
    settle();
    chk("rst_cnt", outstanding_cnt, 5'd0);
    advance();
    reset = 1'b1;
    drive(0, 0, B_LOAD, 0, 4'd3, 0);
    settle();
    chk("stale_resp", dc_resp_valid, 1'b0);
    advance();
    drive(0, 0, B_LOAD, 0, 0, 0);
    settle();
    chk("stale_err", err_unexpected, 1'b1);
    advance();

    // Randomized traffic against the reference model
    do_reset();
    ic_pend = 0; dc_pend = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!ic_pend && $urandom_range(0, 2) == 0) begin
        ic_pend = 1; ic_req_addr = $urandom;
      end
      if (!dc_pend && $urandom_range(0, 1) == 0) begin
        dc_pend = 1; dc_req_addr = $urandom;
        dc_req_cmd = ($urandom_range(0, 3) == 0) ? B_STORE : B_LOAD;
        dc_req_data = {$urandom, $urandom};
      end
      ic_req_valid = ic_pend;
      dc_req_valid = dc_pend;
      mem2proc_data = {$urandom, $urandom};
      dt = 0;
      if ($urandom_range(0, 99) == 0) dt = $urandom_range(1, NT);
      else if ($urandom_range(0, 2) == 0) begin
        q.delete();
        for (int t = 1; t <= NT; t++) if (m_val[t]) q.push_back(t);
        if (q.size() > 0) dt = q[$urandom_range(0, q.size() - 1)];
      end
      mem2proc_data_tag = 4'(dt);
      q.delete();
      for (int t = 1; t <= NT; t++) if (!m_val[t] || t == dt) q.push_back(t);
      if (q.size() == 0 || $urandom_range(0, 4) == 0) mem2proc_transaction_tag = 0;
      else mem2proc_transaction_tag = 4'(q[$urandom_range(0, q.size() - 1)]);
      ic_flush = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 299) != 0);
      settle();
      advance();
      if (e_icr) ic_pend = 0;
      if (e_dcr) dc_pend = 0;
    end
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
